multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
Multi-cycle control unit that sequences the existing CPU datapath (PC, instruction memory, register file, ALU, data memory) through IF/ID/EXE/MEM/WB states. It replaces single-cycle combinational decode so each instruction takes 3-5 clocks. It consumes the latched opcode and the ALU zero flag. It drives every datapath control strobe plus the instruction-register write enable.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALUOp width
HALT_OP, 6'b111111, opcode that stops the machine

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous active-low reset
opcode  in  OP_W  IR[31:26]; valid from ID until the instruction ends
zero  in  1  ALU zero flag, sampled in EXE
state  out  3  current state: IF=000, ID=001, EXE=010, MEM=100, WB=011, HALT=111
PCWre  out  1  PC load enable
PCSrc  out  2  next PC select: 00 PC+4, 01 branch target, 10 jump target
InsMemRW  out  1  instruction memory read (1=read)
IRWre  out  1  instruction register load enable
Extsel  out  1  1=sign-extend imm16, 0=zero-extend
RegDst  out  1  1=rd, 0=rt
ALUSrcB  out  1  1=extended immediate, 0=RegData2
ALUOp  out  ALUOP_W  000 add, 001 sub, 010 and, 011 or
RD  out  1  data memory read strobe, active-low
WR  out  1  data memory write strobe, active-low
DBDataSrc  out  1  1=memory data to register, 0=ALU result
RegWre  out  1  register file write enable
halted  out  1  high in HALT

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010001, or 010010, ori 010011, sw 100110, lw 100111, beq 110000, j 111000, HALT_OP. All other opcodes are illegal.
- State register is the only sequential element. Reset low forces IF asynchronously. Reset takes effect at any point, including mid-instruction; no strobe may remain asserted once Reset is low.
- Transitions occur on the rising clk edge:
  - IF -> ID always.
  - ID -> IF for j or illegal opcodes; ID -> HALT for HALT_OP; ID -> EXE otherwise.
  - EXE -> IF for beq; EXE -> MEM for lw/sw; EXE -> WB for ALU ops.
  - MEM -> WB for lw; MEM -> IF for sw.
  - WB -> IF.
  - HALT -> HALT until Reset.
- Latency in clocks: j and illegal 2; beq 3; add/sub/and/or/addiu/ori 4; sw 4; lw 5.
- All outputs are combinational from state and opcode (Moore in state, decoded by opcode).
- Reset and IF values: InsMemRW=1, IRWre=1, PCWre=0, PCSrc=00, RegWre=0, RD=1, WR=1, halted=0. All other outputs are 0.
- InsMemRW and IRWre are 1 only in IF.
- PCWre is 1 for exactly one cycle, in the final state of each instruction: ID for j/illegal, EXE for beq, MEM for sw, WB for the others. It is 0 in HALT.
- PCSrc is 10 in ID for j. For beq in EXE it is {1'b0, zero}. It is 00 everywhere else.
- Static decode, held from ID to the end of the instruction:
  - Extsel=1 for addiu/lw/sw/beq, 0 for ori.
  - ALUSrcB=1 for addiu/ori/lw/sw.
  - RegDst=1 for add/sub/and/or.
  - ALUOp: sub/beq -> 001; and -> 010; or/ori -> 011; otherwise 000.
  - DBDataSrc=1 for lw.
- RD=0 only in MEM for lw. WR=0 only in MEM for sw. RD and WR are never low together.
- RegWre=1 only in WB.
- In HALT all strobes are inactive, PCWre=0 and halted=1.
- The opcode input is not sampled in IF; the IR is being loaded then.

Test Plan:
- Hold Reset=0 for 50 ns, then release -> state=000, InsMemRW=1, IRWre=1, PCWre=0, RD=1, WR=1. First edge after release -> state=001.
- opcode=000000 (add) -> states IF,ID,EXE,WB. In WB: RegWre=1, RegDst=1, ALUOp=000, PCWre=1, PCSrc=00. Next state IF. PCWre is high for exactly 1 of 4 cycles.
- opcode=100111 (lw) -> 5 states. In MEM: RD=0, WR=1. In WB: DBDataSrc=1, RegWre=1, ALUSrcB=1, Extsel=1. Repeat with opcode=100110 (sw) -> WR=0 in MEM, PCWre=1 in MEM, next state IF, RegWre never 1.
- opcode=110000 (beq): with zero=1 in EXE -> PCSrc=01, PCWre=1, ALUOp=001; with zero=0 -> PCSrc=00. Both cases reach IF after 3 cycles.
- opcode=111000 (j) -> PCSrc=10 and PCWre=1 in ID, next state IF. Illegal opcode=101010 -> PCWre=1, PCSrc=00 in ID.
- opcode=111111 -> state=111, halted=1, PCWre=0 for 10+ cycles. Drive Reset low in the middle of lw MEM -> state=000 immediately with RD=1, and again while in HALT -> state=000.

Source files
------------

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit: IF/ID/EXE/MEM/WB sequencer driving the datapath control strobes
module multicycle_ctrl_unit #(
    parameter int OP_W = 6,
    parameter int ALUOP_W = 3,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(6'b111111)
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    output logic [2:0]         state,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               InsMemRW,
    output logic               IRWre,
    output logic               Extsel,
    output logic               RegDst,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RD,
    output logic               WR,
    output logic               DBDataSrc,
    output logic               RegWre,
    output logic               halted
);
    typedef enum logic [2:0] {
        S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
        S_WB = 3'b011, S_MEM = 3'b100, S_HALT = 3'b111
    } state_t;
    state_t cur, nxt;
    logic is_add, is_sub, is_addiu, is_and, is_or, is_ori, is_sw, is_lw, is_beq, is_j, is_halt;
    logic is_mem, legal, act;
    assign is_add   = opcode == OP_W'(6'b000000);
    assign is_sub   = opcode == OP_W'(6'b000001);
    assign is_addiu = opcode == OP_W'(6'b000010);
    assign is_and   = opcode == OP_W'(6'b010001);
    assign is_or    = opcode == OP_W'(6'b010010);
    assign is_ori   = opcode == OP_W'(6'b010011);
    assign is_sw    = opcode == OP_W'(6'b100110);
    assign is_lw    = opcode == OP_W'(6'b100111);
    assign is_beq   = opcode == OP_W'(6'b110000);
    assign is_j     = opcode == OP_W'(6'b111000);
    assign is_halt  = opcode == HALT_OP;
    assign is_mem   = is_lw | is_sw;
    assign legal    = is_add | is_sub | is_addiu | is_and | is_or | is_ori | is_mem | is_beq | is_j | is_halt;
    always_ff @(posedge clk or negedge Reset)
        if (!Reset) cur <= S_IF;
        else cur <= nxt;
    always_comb begin
        nxt = S_IF;
        case (cur)
            S_IF:   nxt = S_ID;
            S_ID:   nxt = is_halt ? S_HALT : (is_j || !legal) ? S_IF : S_EXE;
            S_EXE:  nxt = is_beq ? S_IF : is_mem ? S_MEM : S_WB;
            S_MEM:  nxt = is_lw ? S_WB : S_IF;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end
    // opcode is only meaningful once the IR holds it, so decode is gated off in IF and HALT
    assign act       = cur == S_ID || cur == S_EXE || cur == S_MEM || cur == S_WB;
    assign state     = cur;
    assign InsMemRW  = cur == S_IF;
    assign IRWre     = cur == S_IF;
    assign PCWre     = (cur == S_ID && (is_j || !legal)) || (cur == S_EXE && is_beq) ||
                       (cur == S_MEM && is_sw) || cur == S_WB;
    assign PCSrc     = (cur == S_ID && is_j) ? 2'b10 : (cur == S_EXE && is_beq) ? {1'b0, zero} : 2'b00;
    assign Extsel    = act && (is_addiu || is_mem || is_beq);
    assign ALUSrcB   = act && (is_addiu || is_ori || is_mem);
    assign RegDst    = act && (is_add || is_sub || is_and || is_or);
    assign DBDataSrc = act && is_lw;
    assign ALUOp     = !act ? '0 : (is_sub || is_beq) ? ALUOP_W'(3'b001) : is_and ? ALUOP_W'(3'b010) :
                       (is_or || is_ori) ? ALUOP_W'(3'b011) : '0;
    assign RD        = !(cur == S_MEM && is_lw);
    assign WR        = !(cur == S_MEM && is_sw);
    assign RegWre    = cur == S_WB;
    assign halted    = cur == S_HALT;
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit: directed and random instruction streams checked against an instruction-level model
module tb_multicycle_ctrl_unit;
    logic clk = 1'b0;
    logic Reset;
    logic [5:0] opcode;
    logic zero;
    logic [2:0] state;
    logic PCWre, InsMemRW, IRWre, Extsel, RegDst, ALUSrcB, RD, WR, DBDataSrc, RegWre, halted;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] ops [10] = '{6'b000000, 6'b000001, 6'b000010, 6'b010001, 6'b010010,
                             6'b010011, 6'b100110, 6'b100111, 6'b110000, 6'b111000};

    multicycle_ctrl_unit dut (
        .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .PCSrc(PCSrc), .InsMemRW(InsMemRW), .IRWre(IRWre), .Extsel(Extsel),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RD(RD), .WR(WR),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .halted(halted)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {state, PCWre, PCSrc, InsMemRW, IRWre, Extsel, RegDst, ALUSrcB, ALUOp,
                       RD, WR, DBDataSrc, RegWre, halted};

    function automatic int lat_of(input logic [5:0] op);
        case (op)
            6'b111111: return 14;
            6'b000000, 6'b000001, 6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110: return 4;
            6'b100111: return 5;
            6'b110000: return 3;
            default:   return 2;
        endcase
    endfunction

    // expected control word for the k-th clock of an instruction, straight from the instruction rules
    function automatic logic [18:0] model(input logic [5:0] op, input int k, input logic z);
        bit lw = op == 6'b100111, sw = op == 6'b100110, beq = op == 6'b110000, j = op == 6'b111000;
        bit hlt = op == 6'b111111;
        int lat = lat_of(op);
        string ph;
        logic [2:0] st, aluop;
        logic [1:0] pcsrc;
        bit pcw, dec;
        ph = k == 0 ? "IF" : (hlt && k >= 2) ? "HALT" : k == 1 ? "ID" : k == 2 ? "EXE" :
             (k == 3 && (lw || sw)) ? "MEM" : "WB";
        st = ph == "IF" ? 3'd0 : ph == "ID" ? 3'd1 : ph == "EXE" ? 3'd2 : ph == "MEM" ? 3'd4 :
             ph == "WB" ? 3'd3 : 3'd7;
        dec = k >= 1 && !hlt;
        pcw = !hlt && k == lat - 1;
        pcsrc = (j && ph == "ID") ? 2'b10 : (beq && ph == "EXE") ? {1'b0, z} : 2'b00;
        aluop = !dec ? 3'd0 : (op == 6'b000001 || beq) ? 3'd1 : op == 6'b010001 ? 3'd2 :
                (op == 6'b010010 || op == 6'b010011) ? 3'd3 : 3'd0;
        return {st, pcw, pcsrc, ph == "IF", ph == "IF",
                dec && (op == 6'b000010 || lw || sw || beq),
                dec && (op == 6'b000000 || op == 6'b000001 || op == 6'b010001 || op == 6'b010010),
                dec && (op == 6'b000010 || op == 6'b010011 || lw || sw),
                aluop, !(lw && ph == "MEM"), !(sw && ph == "MEM"), dec && lw, ph == "WB", ph == "HALT"};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%05h expected=%05h", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int stop_k);
        int n = lat_of(op);
        for (int k = 0; k < n; k++) begin
            opcode = (k == 0) ? 6'($urandom) : op;
            zero = (k == 2) ? z : 1'($urandom);
            #1;
            chk($sformatf("op%b_k%0d", op, k), obs, model(op, k, z));
            if (k == stop_k) return;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] op;
        Reset = 1'b0;
        opcode = 6'b100111;
        zero = 1'b0;
        #20;
        chk("reset_hold", obs, model(6'b0, 0, 1'b0));
        #30;
        chk("reset_end", obs, model(6'b0, 0, 1'b0));
        Reset = 1'b1;
        run_instr(6'b000000, 1'b0, -1);
        run_instr(6'b100111, 1'b1, -1);
        run_instr(6'b100110, 1'b0, -1);
        run_instr(6'b110000, 1'b1, -1);
        run_instr(6'b110000, 1'b0, -1);
        run_instr(6'b111000, 1'b0, -1);
        run_instr(6'b101010, 1'b0, -1);
        run_instr(6'b100111, 1'b0, 3);
        Reset = 1'b0;
        #1;
        chk("reset_in_lw_mem", obs, model(6'b0, 0, 1'b0));
        @(negedge clk);
        Reset = 1'b1;
        run_instr(6'b010011, 1'b1, -1);
        run_instr(6'b111111, 1'b0, -1);
        Reset = 1'b0;
        #1;
        chk("reset_in_halt", obs, model(6'b0, 0, 1'b0));
        @(negedge clk);
        Reset = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            if (op == 6'b111111) op = 6'b101010;
            run_instr(op, 1'($urandom), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
